writeback_buffer: RTL and testbench
===================================

// Module: writeback_buffer
// PURPOSE
//  Line-granular write-back buffer between the dcache miss interface and Data_Memory.
//  Dirty-victim writes are queued and acked in 1 cycle; memory writes drain in the background.
//  Read misses are served from the buffer on an address match, otherwise sent to memory.
//  Memory reads take priority over drains.
// PARAMETERS
//  DEPTH     2    buffered lines; power of 2, >=1
//  ADDR_W    32   byte address width
//  LINE_W    256  cache line width in bits
//  OFFSET_W  5    line offset bits; line address = addr[ADDR_W-1:OFFSET_W]
// PORTS
//  clk_i           in   1              clock, posedge
//  rst_i           in   1              asynchronous reset, active-high
//  cache_addr_i    in   ADDR_W         request line address from dcache
//  cache_data_i    in   LINE_W         write-back line data
//  cache_enable_i  in   1              request valid; held stable until cache_ack_o
//  cache_write_i   in   1              1 = write-back, 0 = line fill (read)
//  cache_ack_o     out  1              one-cycle completion pulse
//  cache_data_o    out  LINE_W         fill data; valid while cache_ack_o=1 for a read
//  mem_addr_o      out  ADDR_W         Data_Memory address
//  mem_data_o      out  LINE_W         Data_Memory write data
//  mem_enable_o    out  1              memory request; held until mem_ack_i
//  mem_write_o     out  1              memory write select
//  mem_ack_i       in   1              memory completion pulse
//  mem_data_i      in   LINE_W         memory read data, valid with mem_ack_i
//  empty_o         out  1              no buffered lines and no memory op in flight
// BEHAVIOUR
//  Reset: all outputs 0 except empty_o=1; count, pointers, FSMs cleared; contents discarded.
//   Reset mid-operation drops mem_enable_o immediately.
//  Storage: circular FIFO of {line addr, data}. wr_ptr/rd_ptr wrap modulo DEPTH.
//   count is clog2(DEPTH)+1 bits. full = (count==DEPTH).
//  Cache FSM: C_IDLE -> C_ACK -> C_IDLE, or C_IDLE -> C_RD -> C_ACK.
//   Requests are sampled only in C_IDLE and never in the ack cycle.
//   A new request may be presented in the cycle after an ack.
//   Write, not full: push at the sampling edge; cache_ack_o=1 next cycle.
//   Write, full: stay in C_IDLE; accept at the edge after the head drain's mem_ack_i.
//   Read, line address matches a valid entry: forward the youngest match into cache_data_o.
//    cache_ack_o=1 next cycle; no memory access.
//   Read, no match: go to C_RD and raise a read request to the memory arbiter.
//    On mem_ack_i, latch mem_data_i; cache_ack_o=1 the following cycle.
//   cache_data_o is a register; it holds its last value when not acked.
//  Memory FSM: M_IDLE, M_RD, M_WR.
//   In M_IDLE: a pending read goes to M_RD. Otherwise count>0 starts a drain of the head entry (M_WR).
//   mem_* outputs are registered and stable while enable=1; they return to 0 on the ack edge.
//   Minimum 1 idle cycle with mem_enable_o=0 between memory ops.
//   A drain in flight is never aborted. A read arriving mid-drain waits for mem_ack_i, then goes first.
//   Head entry is popped on the drain's mem_ack_i edge and stays forwardable until then.
//  Simultaneous events: a push and a pop on the same edge leave count unchanged, with both pointers advancing.
//   Duplicate write addresses get separate entries; drain order is FIFO, so the last write wins in memory.
//  empty_o = (count==0) && memory FSM in M_IDLE. Bench flush waits for empty_o=1.
// TESTING
//  Memory model: Data_Memory with its fixed ack latency. Line addresses are 32B aligned.
//  T1 Reset held, then released -> all outputs 0, empty_o=1; no mem_enable_o for 5 cycles.
//  T2 Write 0x200 with data D -> cache_ack_o 1 cycle later.
//     Then mem write at 0x200 with data D, held until mem_ack_i.
//     After that, memory[16]=D and empty_o=1.
//  T3 Write 0x200=D, then read 0x200 during the drain -> ack 1 cycle after sampling.
//     cache_data_o=D; no mem read issued.
//  T4 DEPTH=2: writes 0x200, 0x400, 0x600 back-to-back -> third ack is withheld until the first drain's mem_ack_i.
//     Memory sees writes in order 0x200, 0x400, 0x600.
//  T5 Buffer holds 0x200 and memory is idle; read 0x040 -> mem read of 0x040 is issued before the drain.
//     cache_data_o = 256'hECFA...ECFA; the 0x200 drain follows.
//  T6 Assert rst_i mid-drain -> mem_enable_o=0 and cache_ack_o=0 immediately.
//     empty_o=1; no memory write completes.

Source files
------------

// File: rtl/writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : writeback_buffer
// Purpose  : Line write-back FIFO between dcache and Data_Memory; forwards
//            buffered lines to read misses and drains to memory in background.
// Revision : 1.0  initial release
// ============================================================================
module writeback_buffer #(
  parameter int DEPTH    = 2,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 256,
  parameter int OFFSET_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cache_addr_i,
  input  logic [LINE_W-1:0] cache_data_i,
  input  logic              cache_enable_i,
  input  logic              cache_write_i,
  output logic              cache_ack_o,
  output logic [LINE_W-1:0] cache_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              empty_o
);

  localparam int c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w   = $clog2(DEPTH) + 1;
  localparam int c_laddr_w = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {C_IDLE = 2'd0, C_RD = 2'd1, C_ACK = 2'd2} cache_state_t;
  typedef enum logic [1:0] {M_IDLE = 2'd0, M_RD = 2'd1, M_WR = 2'd2} mem_state_t;

  cache_state_t r_c_state, w_c_next;
  mem_state_t   r_m_state, w_m_next;

  logic [c_laddr_w-1:0] r_addr [DEPTH];
  logic [LINE_W-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;

  logic [LINE_W-1:0]    r_cache_data;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [LINE_W-1:0]    r_mem_data;
  logic                 r_mem_enable;
  logic                 r_mem_write;

  logic [c_laddr_w-1:0] w_req_line;
  logic                 w_full;
  logic                 w_hit;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fwd;
  logic                 w_rd_done;
  logic [c_ptr_w-1:0]   w_hit_idx;
  logic [c_ptr_w-1:0]   w_scan_idx;
  logic                 w_unused_offset;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_req_line      = cache_addr_i[ADDR_W-1:OFFSET_W];
  assign w_unused_offset = ^cache_addr_i[OFFSET_W-1:0];
  assign w_full          = (r_count == c_cnt_w'(DEPTH));
  assign w_pop           = (r_m_state == M_WR) && mem_ack_i;
  assign w_rd_done       = (r_m_state == M_RD) && mem_ack_i;

  assign cache_ack_o  = (r_c_state == C_ACK);
  assign cache_data_o = r_cache_data;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign empty_o      = (r_count == '0) && (r_m_state == M_IDLE);

  // Scan oldest to youngest so the last match kept is the youngest copy.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = c_ptr_w'((int'(r_rd_ptr) + k) % DEPTH);
      if (r_valid[w_scan_idx] && (r_addr[w_scan_idx] == w_req_line)) begin
        w_hit     = 1'b1;
        w_hit_idx = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_c_next = r_c_state;
    w_push   = 1'b0;
    w_fwd    = 1'b0;
    case (r_c_state)
      C_IDLE: begin
        if (cache_enable_i) begin
          if (cache_write_i) begin
            if (!w_full) begin
              w_push   = 1'b1;
              w_c_next = C_ACK;
            end
          end else if (w_hit) begin
            w_fwd    = 1'b1;
            w_c_next = C_ACK;
          end else begin
            w_c_next = C_RD;
          end
        end
      end
      C_RD:    if (w_rd_done) w_c_next = C_ACK;
      C_ACK:   w_c_next = C_IDLE;
      default: w_c_next = C_IDLE;
    endcase
  end

  // A waiting read miss wins over a drain whenever memory is free.
  always_comb begin
    w_m_next = r_m_state;
    case (r_m_state)
      M_IDLE: begin
        if (r_c_state == C_RD)  w_m_next = M_RD;
        else if (r_count != '0) w_m_next = M_WR;
      end
      M_RD, M_WR: if (mem_ack_i) w_m_next = M_IDLE;
      default:    w_m_next = M_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_c_state <= C_IDLE;
      r_m_state <= M_IDLE;
    end else begin
      r_c_state <= w_c_next;
      r_m_state <= w_m_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= w_req_line;
      r_data[r_wr_ptr] <= cache_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr           <= ptr_inc(r_wr_ptr);
        r_valid[r_wr_ptr]  <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr           <= ptr_inc(r_rd_ptr);
        r_valid[r_rd_ptr]  <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (r_m_state == M_IDLE) begin
      if (w_m_next == M_RD) begin
        r_mem_addr   <= {w_req_line, {OFFSET_W{1'b0}}};
        r_mem_data   <= '0;
        r_mem_enable <= 1'b1;
        r_mem_write  <= 1'b0;
      end else if (w_m_next == M_WR) begin
        r_mem_addr   <= {r_addr[r_rd_ptr], {OFFSET_W{1'b0}}};
        r_mem_data   <= r_data[r_rd_ptr];
        r_mem_enable <= 1'b1;
        r_mem_write  <= 1'b1;
      end
    end else if (mem_ack_i) begin
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cache_data <= '0;
    end else if (w_fwd) begin
      r_cache_data <= r_data[w_hit_idx];
    end else if (w_rd_done) begin
      r_cache_data <= mem_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_buffer
// Purpose  : Directed vector bench for writeback_buffer with a fixed-latency
//            Data_Memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_writeback_buffer;

  localparam int LAT = 3;

  logic         clk;
  logic         rst;
  logic [31:0]  cache_addr;
  logic [255:0] cache_wdata;
  logic         cache_en;
  logic         cache_wr;
  logic         cache_ack;
  logic [255:0] cache_rdata;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic         mem_en;
  logic         mem_wr;
  logic         mem_ack;
  logic [255:0] mem_rdata;
  logic         empty;

  int checks = 0;
  int errors = 0;

  writeback_buffer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cache_addr_i   (cache_addr),
    .cache_data_i   (cache_wdata),
    .cache_enable_i (cache_en),
    .cache_write_i  (cache_wr),
    .cache_ack_o    (cache_ack),
    .cache_data_o   (cache_rdata),
    .mem_addr_o     (mem_addr),
    .mem_data_o     (mem_wdata),
    .mem_enable_o   (mem_en),
    .mem_write_o    (mem_wr),
    .mem_ack_i      (mem_ack),
    .mem_data_i     (mem_rdata),
    .empty_o        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data_Memory model: 64 lines, ack raised on the LAT-th cycle of a request.
  logic [255:0] mem_arr [64];
  bit           written [64];
  logic [32:0]  op_log  [32];
  int           op_n     = 0;
  int           rd_n     = 0;
  int           prot_err = 0;
  int           lat_cnt  = 0;
  logic [31:0]  cap_addr;
  logic [255:0] cap_data;
  logic         cap_wr;

  function automatic logic [255:0] dflt(input int idx);
    if (idx == 2) return {16{16'hECFA}};
    return {8{32'hA500_0000 | idx}};
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin : mem_model
    int idx;
    if (mem_ack) begin
      if (mem_en) prot_err++;
      mem_ack = 1'b0;
      lat_cnt = 0;
    end else if (mem_en && !rst) begin
      if (lat_cnt == 0) begin
        cap_addr = mem_addr;
        cap_data = mem_wdata;
        cap_wr   = mem_wr;
      end else if (cap_addr !== mem_addr || cap_data !== mem_wdata || cap_wr !== mem_wr) begin
        prot_err++;
      end
      lat_cnt++;
      if (lat_cnt == LAT) begin
        idx = int'(mem_addr[10:5]);
        if (mem_wr) begin
          mem_arr[idx] = mem_wdata;
          written[idx] = 1'b1;
        end else begin
          mem_rdata = written[idx] ? mem_arr[idx] : dflt(idx);
          rd_n++;
        end
        if (op_n < 32) op_log[op_n] = {mem_wr, mem_addr};
        op_n++;
        mem_ack = 1'b1;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; returns edges until ack and the data seen.
  task automatic cache_req(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                           output int lat, output logic [255:0] rdata);
    lat         = 0;
    cache_addr  = addr;
    cache_wdata = data;
    cache_wr    = wr;
    cache_en    = 1'b1;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (cache_ack) break;
    end
    rdata = cache_rdata;
    if (!cache_ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no cache_ack_o for addr %0h after %0d cycles", addr, lat);
      lat = -1;
    end
    cache_en = 1'b0;
    cache_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic flush();
    int n = 0;
    while (!empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!empty) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout: empty_o=%0b after %0d cycles, required 1", empty, n);
    end
  endtask

  typedef struct {
    bit           flush;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           exp_lat;
    logic [255:0] exp_data;
    int           exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [255:0] d1, d2, d3, a, b, c, p, q, ecfa, rdata;
    int lat, rd0, base;
    bit en_seen;

    d1   = {8{32'h1111_0001}};
    d2   = {8{32'h2222_0002}};
    d3   = {8{32'h3333_0003}};
    a    = {8{32'hAAAA_000A}};
    b    = {8{32'hBBBB_000B}};
    c    = {8{32'hCCCC_000C}};
    p    = {8{32'h5555_0005}};
    q    = {8{32'h6666_0006}};
    ecfa = {16{16'hECFA}};

    // flush, wr, addr, data, latency, read data, memory reads issued
    vecs[0] = '{1'b1, 1'b1, 32'h200, d1, 1, '0,   0};
    vecs[1] = '{1'b0, 1'b0, 32'h200, '0, 1, d1,   0};
    vecs[2] = '{1'b1, 1'b0, 32'h200, '0, 5, d1,   1};
    vecs[3] = '{1'b1, 1'b1, 32'h400, d2, 1, '0,   0};
    vecs[4] = '{1'b0, 1'b1, 32'h400, d3, 1, '0,   0};
    vecs[5] = '{1'b0, 1'b0, 32'h400, '0, 1, d3,   0};
    vecs[6] = '{1'b1, 1'b0, 32'h400, '0, 5, d3,   1};
    vecs[7] = '{1'b0, 1'b0, 32'h040, '0, 5, ecfa, 1};

    rst         = 1'b1;
    cache_addr  = '0;
    cache_wdata = '0;
    cache_en    = 1'b0;
    cache_wr    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cache_ack",  cache_ack,   0);
    chk("rst_cache_data", cache_rdata, 0);
    chk("rst_mem_addr",   mem_addr,    0);
    chk("rst_mem_data",   mem_wdata,   0);
    chk("rst_mem_enable", mem_en,      0);
    chk("rst_mem_write",  mem_wr,      0);
    chk("rst_empty",      empty,       1);
    rst     = 1'b0;
    en_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_en) en_seen = 1'b1;
    end
    chk("idle_after_reset", en_seen, 0);

    // Table-driven single requests
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].flush) flush();
      rd0 = rd_n;
      cache_req(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, rdata);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].wr) chk($sformatf("v%0d_data", i), rdata, vecs[i].exp_data);
      chk($sformatf("v%0d_mem_reads", i), rd_n - rd0, vecs[i].exp_rd);
    end
    chk("mem_line16", mem_arr[16], d1);

    // Full buffer: third write held until the first drain completes
    flush();
    base = op_n;
    cache_req(1'b1, 32'h200, a, lat, rdata);
    chk("full_w1_latency", lat, 1);
    cache_req(1'b1, 32'h400, b, lat, rdata);
    chk("full_w2_latency", lat, 1);
    cache_req(1'b1, 32'h600, c, lat, rdata);
    chk("full_w3_latency", lat, 2);
    chk("full_drains_before_w3", op_n - base, 1);
    flush();
    chk("full_order0", op_log[base],     {1'b1, 32'h200});
    chk("full_order1", op_log[base + 1], {1'b1, 32'h400});
    chk("full_order2", op_log[base + 2], {1'b1, 32'h600});
    chk("mem_line48",  mem_arr[48], c);

    // Read miss arriving mid-drain goes ahead of the remaining buffered line
    base = op_n;
    cache_req(1'b1, 32'h100, p, lat, rdata);
    cache_req(1'b1, 32'h200, q, lat, rdata);
    cache_req(1'b0, 32'h040, '0, lat, rdata);
    chk("prio_rd_latency", lat, 5);
    chk("prio_rd_data", rdata, ecfa);
    flush();
    chk("prio_order0", op_log[base],     {1'b1, 32'h100});
    chk("prio_order1", op_log[base + 1], {1'b0, 32'h040});
    chk("prio_order2", op_log[base + 2], {1'b1, 32'h200});
    chk("data_hold", cache_rdata, ecfa);

    // Reset in the middle of a drain
    base = op_n;
    cache_req(1'b1, 32'h300, d2, lat, rdata);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_mem_enable", mem_en,    0);
    chk("midrst_cache_ack",  cache_ack, 0);
    chk("midrst_empty",      empty,     1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_no_write", op_n - base, 0);
    chk("midrst_empty_after", empty, 1);

    chk("mem_protocol", prot_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
